// File: rtl/mac_tree_acc.sv
`default_nettype none
// ============================================================================
// Module : mac_tree_acc
// Brief  : Pipelined signed adder tree feeding a first/last windowed
//          accumulator, followed by round-to-nearest rescale and saturation.
// Rev    : 1.0
// ============================================================================
module mac_tree_acc #(
    parameter  int NUM_IN  = 144,
    parameter  int IN_W    = 16,
    parameter  int OUT_W   = 8,
    parameter  int ACC_EXT = 8,
    localparam int D       = $clog2(NUM_IN),
    localparam int ACC_W   = IN_W + D + ACC_EXT,
    localparam int SH_W    = $clog2(ACC_W)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     vld_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic [SH_W-1:0]          shift_i,
    input  logic [NUM_IN*IN_W-1:0]   din,
    output logic signed [OUT_W-1:0]  acc_o,
    output logic                     vld_o,
    output logic                     sat_o
);

    localparam int TREE_W = IN_W + D;
    localparam int SB_W   = SH_W + 3;

    localparam logic [SH_W-1:0]       c_sh_max  = SH_W'(ACC_W - 1);
    localparam logic signed [ACC_W:0] c_rnd_one = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] c_out_max = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] c_out_min = ~c_out_max;

    // Number of nodes at a given tree level (ceil-halving from NUM_IN).
    function automatic int lvl_cnt(input int lvl);
        int n;
        n = NUM_IN;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Reduction tree. Each level keeps its own natural width in its
    // registers; w_lvl is only a uniform-width view for wiring levels.
    // ------------------------------------------------------------------
    logic signed [TREE_W-1:0] w_lvl [D+1][NUM_IN];

    generate
        for (genvar k = 0; k < NUM_IN; k++) begin : g_in
            assign w_lvl[0][k] = {{D{din[k*IN_W+IN_W-1]}}, din[k*IN_W +: IN_W]};
        end

        for (genvar l = 1; l <= D; l++) begin : g_lvl
            localparam int N_PREV = lvl_cnt(l - 1);
            localparam int N_CUR  = lvl_cnt(l);
            localparam int W      = IN_W + l;

            for (genvar k = 0; k < NUM_IN; k++) begin : g_node
                if (k < N_CUR) begin : g_used
                    logic signed [W-1:0] w_a;
                    logic signed [W-1:0] w_b;
                    logic signed [W-1:0] r_sum;

                    assign w_a = w_lvl[l-1][2*k][W-1:0];
                    if (2*k + 1 < N_PREV) begin : g_pair
                        assign w_b = w_lvl[l-1][2*k+1][W-1:0];
                    end else begin : g_odd
                        // Odd leftover still takes a register so every path has depth D.
                        assign w_b = '0;
                    end

                    always_ff @(posedge clk or negedge rstn) begin
                        if (!rstn) r_sum <= '0;
                        else       r_sum <= w_a + w_b;
                    end

                    assign w_lvl[l][k] = TREE_W'(r_sum);
                end else begin : g_pad
                    assign w_lvl[l][k] = '0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sideband pipe aligned with the tree: {vld, first, last, shift}.
    // ------------------------------------------------------------------
    logic [SB_W-1:0] r_sb [D];
    logic [SB_W-1:0] w_sb_in;
    logic            w_sb_vld;
    logic            w_sb_first;
    logic            w_sb_last;
    logic [SH_W-1:0] w_sb_shift;

    assign w_sb_in = {vld_i, vld_i & first_i, vld_i & last_i, shift_i};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < D; i++) r_sb[i] <= '0;
        end else begin
            r_sb[0] <= w_sb_in;
            for (int i = 1; i < D; i++) r_sb[i] <= r_sb[i-1];
        end
    end

    assign w_sb_vld   = r_sb[D-1][SB_W-1];
    assign w_sb_first = r_sb[D-1][SB_W-2];
    assign w_sb_last  = r_sb[D-1][SB_W-3];
    assign w_sb_shift = r_sb[D-1][SH_W-1:0];

    // ------------------------------------------------------------------
    // Window accumulator
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_acc_vld;
    logic [SH_W-1:0]         r_acc_sh;
    logic signed [ACC_W-1:0] w_tree_sum;

    assign w_tree_sum = ACC_W'(w_lvl[D][0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_acc_vld <= 1'b0;
            r_acc_sh  <= '0;
        end else begin
            r_acc_vld <= w_sb_vld & w_sb_last;
            if (w_sb_vld) begin
                // A beat arriving while idle opens a window even without first.
                if (r_state == ST_IDLE || w_sb_first) r_acc <= w_tree_sum;
                else                                  r_acc <= r_acc + w_tree_sum;
                r_state <= w_sb_last ? ST_IDLE : ST_OPEN;
                if (w_sb_last) r_acc_sh <= w_sb_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-to-nearest arithmetic shift, one bit wider than the accumulator
    // ------------------------------------------------------------------
    logic [SH_W-1:0]       w_sh;
    logic signed [ACC_W:0] w_bias;
    logic signed [ACC_W:0] w_rnd_sum;
    logic signed [ACC_W:0] w_rnd;
    logic signed [ACC_W:0] r_rnd;
    logic                  r_rnd_vld;

    always_comb begin
        w_sh      = (r_acc_sh > c_sh_max) ? c_sh_max : r_acc_sh;
        w_bias    = (w_sh == '0) ? '0 : (c_rnd_one <<< (w_sh - SH_W'(1)));
        w_rnd_sum = {r_acc[ACC_W-1], r_acc} + w_bias;
        w_rnd     = w_rnd_sum >>> w_sh;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rnd     <= '0;
            r_rnd_vld <= 1'b0;
        end else begin
            r_rnd_vld <= r_acc_vld;
            if (r_acc_vld) r_rnd <= w_rnd;
        end
    end

    // ------------------------------------------------------------------
    // Saturation and output registers
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0] r_out_acc;
    logic                    r_out_vld;
    logic                    r_out_sat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_acc <= '0;
            r_out_vld <= 1'b0;
            r_out_sat <= 1'b0;
        end else begin
            r_out_vld <= r_rnd_vld;
            if (r_rnd_vld) begin
                if (r_rnd > c_out_max) begin
                    r_out_acc <= c_out_max[OUT_W-1:0];
                    r_out_sat <= 1'b1;
                end else if (r_rnd < c_out_min) begin
                    r_out_acc <= c_out_min[OUT_W-1:0];
                    r_out_sat <= 1'b1;
                end else begin
                    r_out_acc <= r_rnd[OUT_W-1:0];
                    r_out_sat <= 1'b0;
                end
            end
        end
    end

    assign acc_o = r_out_acc;
    assign vld_o = r_out_vld;
    assign sat_o = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_tree_acc.sv
`default_nettype none
// ============================================================================
// Module : tb_mac_tree_acc
// Brief  : Directed self-checking bench for mac_tree_acc (NUM_IN=144).
// Rev    : 1.0
// ============================================================================
module tb_mac_tree_acc;

    localparam int NUM_IN  = 144;
    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int ACC_EXT = 8;
    localparam int SH_W    = 5;
    localparam int LAT     = 11;

    logic                    clk;
    logic                    rstn;
    logic                    vld_i;
    logic                    first_i;
    logic                    last_i;
    logic [SH_W-1:0]         shift_i;
    logic [NUM_IN*IN_W-1:0]  din;
    logic signed [OUT_W-1:0] acc_o;
    logic                    vld_o;
    logic                    sat_o;

    int n_run  = 0;
    int n_fail = 0;

    mac_tree_acc #(
        .NUM_IN  (NUM_IN),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .ACC_EXT (ACC_EXT)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .vld_i   (vld_i),
        .first_i (first_i),
        .last_i  (last_i),
        .shift_i (shift_i),
        .din     (din),
        .acc_o   (acc_o),
        .vld_o   (vld_o),
        .sat_o   (sat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [IN_W-1:0] v);
        for (int k = 0; k < NUM_IN; k++) din[k*IN_W +: IN_W] = v;
    endtask

    task automatic set_one(input int v);
        logic [31:0] t;
        t = v;
        set_all('0);
        din[IN_W-1:0] = t[IN_W-1:0];
    endtask

    task automatic drive_beat(input bit f, input bit l, input logic [SH_W-1:0] sh);
        vld_i   = 1'b1;
        first_i = f;
        last_i  = l;
        shift_i = sh;
    endtask

    // Called right after the closing beat has been driven (before its edge).
    task automatic wait_result(input string tag, input int exp_acc, input bit exp_sat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                vld_i   = 1'b0;
                first_i = 1'b0;
                last_i  = 1'b0;
            end
            if (vld_o) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, LAT);
        if (lat != 0) begin
            chk({tag, "_acc"}, acc_o, exp_acc);
            chk({tag, "_sat"}, {31'd0, sat_o}, {31'd0, exp_sat});
            @(posedge clk); #1;
            chk({tag, "_pulse"}, {31'd0, vld_o}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bb_sum [4];
        int bb_exp [4];
        int got [4];
        int n_seen, first_k, last_k, idle_hits;

        bb_sum = '{16, 32, -16, 0};
        bb_exp = '{1, 2, -1, 0};

        rstn = 1'b0; vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
        shift_i = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_acc", acc_o, 0);
        chk("reset_vld", {31'd0, vld_o}, 0);
        chk("reset_sat", {31'd0, sat_o}, 0);
        @(negedge clk); rstn = 1'b1;

        // Flags without valid must be ignored.
        first_i = 1'b1; last_i = 1'b1; shift_i = 5'd4; set_all(16'h0001);
        idle_hits = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (vld_o) idle_hits++;
        end
        chk("idle_flags", idle_hits, 0);
        first_i = 1'b0; last_i = 1'b0;

        @(negedge clk); set_all(16'h0001); drive_beat(1, 1, 5'd4);
        wait_result("ones_sh4", 9, 1'b0);

        @(negedge clk); set_all(16'hFFFF); drive_beat(1, 1, 5'd4);
        wait_result("negs_sh4", -9, 1'b0);

        @(negedge clk); set_all(16'hFFFF); drive_beat(1, 1, 5'd0);
        wait_result("negs_sh0", -128, 1'b1);

        // Three-beat window with a bubble before the closing beat: 432 -> 27.
        @(negedge clk); set_all(16'h0001); drive_beat(1, 0, 5'd0);
        @(negedge clk); drive_beat(0, 0, 5'd0);
        @(negedge clk); vld_i = 1'b0;
        @(negedge clk); drive_beat(0, 1, 5'd4);
        wait_result("three_beat", 27, 1'b0);

        @(negedge clk); set_all(16'h7FFF); drive_beat(1, 1, 5'd0);
        wait_result("pos_sat", 127, 1'b1);

        @(negedge clk); set_all(16'h8000); drive_beat(1, 1, 5'd0);
        wait_result("neg_sat", -128, 1'b1);

        // Reset in the middle of an open window drops it.
        @(negedge clk); set_all(16'h0001); drive_beat(1, 0, 5'd4);
        @(posedge clk); #1; vld_i = 1'b0; first_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rstn = 1'b0;
        #1;
        chk("midrst_acc", acc_o, 0);
        chk("midrst_vld", {31'd0, vld_o}, 0);
        chk("midrst_sat", {31'd0, sat_o}, 0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); set_all(16'h0001); drive_beat(1, 1, 5'd4);
        wait_result("post_rst", 9, 1'b0);

        // Four back-to-back single-beat windows.
        n_seen = 0; first_k = 0; last_k = 0;
        @(negedge clk); set_one(bb_sum[0]); drive_beat(1, 1, 5'd4);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (vld_o) begin
                if (n_seen == 0) first_k = k;
                if (n_seen < 4) got[n_seen] = acc_o;
                n_seen++;
                last_k = k;
            end
            if (k < 4) begin
                set_one(bb_sum[k]);
                drive_beat(1, 1, 5'd4);
            end else begin
                vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
            end
        end
        chk("b2b_first", first_k, LAT);
        chk("b2b_count", n_seen, 4);
        chk("b2b_last", last_k, LAT + 3);
        for (int j = 0; j < 4; j++) begin
            if (j < n_seen) chk($sformatf("b2b_acc%0d", j), got[j], bb_exp[j]);
            else            chk($sformatf("b2b_acc%0d", j), 32'sd999, bb_exp[j]);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
